des_key_schedule: RTL



---
 rtl/des_pkg.sv | 52 +++++
 rtl/des_key_schedule_if.sv | 19 +
 rtl/des_pc2_perm.sv | 9 +
 rtl/des_key_schedule.sv | 114 +++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule tables, typedefs and bit-permutation helpers.
// Bit numbering follows DES: bit 1 is the MSB, i.e. the highest index of each [N:1] vector.
package des_pkg;

   typedef logic [64:1] key64_t;
   typedef logic [28:1] half28_t;
   typedef logic [48:1] subkey48_t;

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} ks_state_t;

   localparam logic [6:0] PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam logic [5:0] PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam logic [1:0] SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic logic [56:1] pc1(input key64_t k);
      logic [56:1] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(56 - i)] = k[7'd65 - PC1_T[i]];
      return r;
   endfunction

   function automatic subkey48_t pc2(input logic [56:1] cd);
      subkey48_t r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(48 - i)] = cd[6'd57 - PC2_T[i]];
      return r;
   endfunction

   // Round 16 is carried as 4'd0, which the -1 wraps onto the last table entry.
   function automatic logic [1:0] shift_of(input logic [3:0] rnd);
      return SHIFT_T[rnd - 4'd1];
   endfunction

   function automatic half28_t rotl28(input half28_t h, input logic [1:0] n);
      return (n == 2'd2) ? {h[26:1], h[28:27]} : {h[27:1], h[28]};
   endfunction

   function automatic half28_t rotr28(input half28_t h, input logic [1:0] n);
      return (n == 2'd2) ? {h[2:1], h[28:3]} : {h[1], h[28:2]};
   endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle between key source, key schedule and round engine.
interface des_key_schedule_if;
   import des_pkg::*;

   key64_t    key;
   logic      mode;
   logic      key_valid;
   logic      key_ready;
   subkey48_t subkey;
   logic [3:0] round;
   logic      last;
   logic      sk_valid;
   logic      sk_ready;

   modport slave  (input  key, mode, key_valid, sk_ready,
                   output key_ready, subkey, round, last, sk_valid);
   modport master (output key, mode, key_valid, sk_ready,
                   input  key_ready, subkey, round, last, sk_valid);
endinterface

// File: rtl/des_pc2_perm.sv
// Combinational PC-2: compresses the 56-bit C||D state into a 48-bit round subkey.
module des_pc2_perm
   import des_pkg::*;
(
   input  logic [56:1] cd_i,
   output subkey48_t   subkey_o
);
   assign subkey_o = pc2(cd_i);
endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one key in, sixteen PC-2 subkeys out over valid/ready,
// forward order for encrypt and reverse order for decrypt.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
) (
   input  logic               clk,
   input  logic               reset,
   des_key_schedule_if.slave  ks
);

   ks_state_t  state_q, state_d;
   half28_t    c_q, c_d, d_q, d_d;
   logic       mode_q, mode_d;
   logic [4:0] count_q, count_d;
   logic [3:0] round_q, round_d;
   subkey48_t  subkey_q, subkey_d;
   logic       sk_valid_q, last_q, key_ready_q;
   logic [1:0] sh;
   logic [56:1] pc1_key;
   logic       hs;

   assign pc1_key = pc1(ks.key);
   assign hs      = sk_valid_q && ks.sk_ready;

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      mode_d  = mode_q;
      count_d = count_q;
      round_d = round_q;
      sh      = '0;
      unique case (state_q)
         IDLE: if (ks.key_valid && key_ready_q) begin
            {c_d, d_d} = pc1_key;
            mode_d     = ks.mode;
            count_d    = 5'd1;
            state_d    = LOAD;
         end
         // Decrypt starts from C16/D16, which equal C0/D0 after the full 28-bit rotation.
         LOAD: begin
            if (!mode_q) begin
               sh      = shift_of(4'd1);
               c_d     = rotl28(c_q, sh);
               d_d     = rotl28(d_q, sh);
               round_d = 4'd1;
            end else begin
               round_d = 4'd0;
            end
            state_d = EMIT;
         end
         EMIT: if (hs) begin
            if (count_q == 5'(ROUNDS)) begin
               state_d = IDLE;
            end else begin
               if (!mode_q) begin
                  sh      = shift_of(round_q + 4'd1);
                  c_d     = rotl28(c_q, sh);
                  d_d     = rotl28(d_q, sh);
                  round_d = round_q + 4'd1;
               end else begin
                  sh      = shift_of(round_q);
                  c_d     = rotr28(c_q, sh);
                  d_d     = rotr28(d_q, sh);
                  round_d = round_q - 4'd1;
               end
               count_d = count_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Subkey is registered from the next C/D so it always matches the round shown.
   des_pc2_perm u_pc2 (
      .cd_i     ({c_d, d_d}),
      .subkey_o (subkey_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         c_q         <= '0;
         d_q         <= '0;
         mode_q      <= 1'b0;
         count_q     <= '0;
         round_q     <= '0;
         subkey_q    <= '0;
         sk_valid_q  <= 1'b0;
         last_q      <= 1'b0;
         key_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         round_q     <= round_d;
         subkey_q    <= subkey_d;
         sk_valid_q  <= (state_d == EMIT);
         last_q      <= (state_d == EMIT) && (count_d == 5'(ROUNDS));
         key_ready_q <= (state_d == IDLE);
      end
   end

   assign ks.key_ready = key_ready_q;
   assign ks.sk_valid  = sk_valid_q;
   assign ks.subkey    = subkey_q;
   assign ks.round     = round_q;
   assign ks.last      = last_q;

endmodule
